mlp_acq_sequencer: RTL and testbench

MLP_ACQ_SEQUENCER -- requirements
Module: mlp_acq_sequencer

---
 rtl/mlp_seq_pkg.sv | 18 +
 rtl/mlp_acq_sequencer.sv | 141 ++++++++++++++
 tb/tb_mlp_acq_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_seq_pkg.sv
// Shared constants and state encoding for the MLP acquisition sequencer.
package mlp_seq_pkg;

  localparam int unsigned DEF_N_CH          = 6;
  localparam int unsigned DEF_ADC_BITS      = 4;
  localparam int unsigned DEF_CLS_BITS      = 2;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_ADC_TIMEOUT   = 16;

  typedef enum logic [2:0] {
    StIdle,
    StConvStart,
    StConvWait,
    StSettle,
    StHold
  } seq_state_e;

endpackage

// File: rtl/mlp_acq_sequencer.sv
// Sequences N_CH ADC conversions into a feature vector, lets an external
// combinational classifier settle, then holds the registered class until accepted.
module mlp_acq_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int unsigned N_CH          = DEF_N_CH,
  parameter int unsigned ADC_BITS      = DEF_ADC_BITS,
  parameter int unsigned CLS_BITS      = DEF_CLS_BITS,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned ADC_TIMEOUT   = DEF_ADC_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     adc_start_o,
  output logic [2:0]               adc_ch_o,
  input  logic                     adc_done_i,
  input  logic [ADC_BITS-1:0]      adc_data_i,
  output logic [N_CH*ADC_BITS-1:0] feat_o,
  input  logic [CLS_BITS-1:0]      class_i,
  output logic [CLS_BITS-1:0]      class_o,
  output logic                     class_valid_o,
  input  logic                     class_ready_i,
  output logic                     err_o
);

  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned TMR_W = $clog2(ADC_TIMEOUT + 1);
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(N_CH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(ADC_TIMEOUT - 1);
  localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE_CYCLES - 1);

  seq_state_e                state_q;
  logic [CH_W-1:0]           ch_q;
  logic [TMR_W-1:0]          timer_q;
  logic [SET_W-1:0]          settle_q;
  logic [N_CH*ADC_BITS-1:0]  feat_q;
  logic [CLS_BITS-1:0]       class_q;
  logic                      busy_q;
  logic                      adc_start_q;
  logic                      class_valid_q;
  logic                      err_q;

  logic                      conv_end;
  logic [ADC_BITS-1:0]       sample;

  // A timed-out channel is finished as if done, with a zero sample.
  always_comb begin
    conv_end = adc_done_i || (timer_q == TMR_LAST);
    sample   = adc_done_i ? adc_data_i : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ch_q          <= '0;
      timer_q       <= '0;
      settle_q      <= '0;
      feat_q        <= '0;
      class_q       <= '0;
      busy_q        <= 1'b0;
      adc_start_q   <= 1'b0;
      class_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      adc_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            err_q       <= 1'b0;
            ch_q        <= '0;
            busy_q      <= 1'b1;
            adc_start_q <= 1'b1;
            state_q     <= StConvStart;
          end
        end
        StConvStart: begin
          timer_q <= '0;
          state_q <= StConvWait;
        end
        StConvWait: begin
          if (conv_end) begin
            for (int k = 0; k < N_CH; k++) begin
              if (ch_q == CH_W'(k)) feat_q[k*ADC_BITS +: ADC_BITS] <= sample;
            end
            if (!adc_done_i) err_q <= 1'b1;
            if (ch_q == LAST_CH) begin
              settle_q <= '0;
              state_q  <= StSettle;
            end else begin
              ch_q        <= ch_q + CH_W'(1);
              adc_start_q <= 1'b1;
              state_q     <= StConvStart;
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        StSettle: begin
          if (settle_q == SET_LAST) begin
            class_q       <= class_i;
            class_valid_q <= 1'b1;
            state_q       <= StHold;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end
        StHold: begin
          if (class_ready_i) begin
            class_valid_q <= 1'b0;
            if (start_i) begin
              err_q       <= 1'b0;
              ch_q        <= '0;
              adc_start_q <= 1'b1;
              state_q     <= StConvStart;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign adc_start_o   = adc_start_q;
  assign adc_ch_o      = 3'(ch_q);
  assign feat_o        = feat_q;
  assign class_o       = class_q;
  assign class_valid_o = class_valid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_mlp_acq_sequencer.sv
// Directed bench for mlp_acq_sequencer with a one-cycle-latency ADC model.
module tb_mlp_acq_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        busy_o;
  logic        adc_start_o;
  logic [2:0]  adc_ch_o;
  logic        adc_done_i;
  logic [3:0]  adc_data_i;
  logic [23:0] feat_o;
  logic [1:0]  class_i;
  logic [1:0]  class_o;
  logic        class_valid_o;
  logic        class_ready_i;
  logic        err_o;

  int vectors = 0;
  int miscompares = 0;
  int strobe_cnt = 0;
  int skip_ch = -1;
  int edges = 0;
  logic       pend = 1'b0;
  logic [2:0] pend_ch = 3'd0;

  mlp_acq_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .busy_o        (busy_o),
    .adc_start_o   (adc_start_o),
    .adc_ch_o      (adc_ch_o),
    .adc_done_i    (adc_done_i),
    .adc_data_i    (adc_data_i),
    .feat_o        (feat_o),
    .class_i       (class_i),
    .class_o       (class_o),
    .class_valid_o (class_valid_o),
    .class_ready_i (class_ready_i),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  // ADC answers channel k with value k+1 in the cycle after the strobe,
  // except for skip_ch, which never answers.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend       = 1'b0;
      adc_done_i = 1'b0;
      adc_data_i = 4'h0;
    end else begin
      adc_done_i = pend;
      adc_data_i = pend ? 4'(pend_ch + 3'd1) : 4'h0;
      pend       = adc_start_o && (int'(adc_ch_o) != skip_ch);
      pend_ch    = adc_ch_o;
      if (adc_start_o) strobe_cnt++;
    end
  end

  task automatic accept();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    edges = 1;
  endtask

  task automatic wait_valid();
    while (!class_valid_o && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic release_hold();
    class_ready_i = 1'b1;
    @(posedge clk); #1;
    class_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; class_i = 2'd0; class_ready_i = 1'b0;
    #1;
    vectors++;
    if ({busy_o, adc_start_o, adc_ch_o, feat_o, class_o, class_valid_o, err_o} !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h exp=0",
               {busy_o, adc_start_o, adc_ch_o, feat_o, class_o, class_valid_o, err_o});
    end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    strobe_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (strobe_cnt !== 0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle strobes=%0d busy=%b exp strobes=0 busy=0", strobe_cnt, busy_o);
    end
  endtask

  task automatic test_nominal();
    class_i = 2'd2;
    accept();
    vectors++;
    if (busy_o !== 1'b1 || adc_start_o !== 1'b1 || adc_ch_o !== 3'd0) begin
      miscompares++;
      $display("FAIL first_strobe busy=%b strobe=%b ch=%0d exp 1 1 0", busy_o, adc_start_o, adc_ch_o);
    end
    wait_valid();
    vectors++;
    if (edges !== 17) begin
      miscompares++;
      $display("FAIL nominal_latency got=%0d exp=17", edges);
    end
    vectors++;
    if (feat_o !== 24'h654321 || class_o !== 2'd2 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_result feat=%h cls=%0d err=%b exp 654321 2 0", feat_o, class_o, err_o);
    end
    release_hold();
    vectors++;
    if (busy_o !== 1'b0 || class_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_release busy=%b valid=%b exp 0 0", busy_o, class_valid_o);
    end
  endtask

  task automatic test_timeout();
    skip_ch = 3;
    class_i = 2'd0;
    accept();
    wait_valid();
    vectors++;
    if (edges !== 32) begin
      miscompares++;
      $display("FAIL timeout_latency got=%0d exp=32", edges);
    end
    vectors++;
    if (feat_o !== 24'h650321 || err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_result feat=%h err=%b exp 650321 1", feat_o, err_o);
    end
  endtask

  // Entered while holding the timed-out result with err_o set.
  task automatic test_back_to_back();
    skip_ch = -1;
    class_i = 2'd1;
    class_ready_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    class_ready_i = 1'b0;
    start_i = 1'b0;
    edges = 1;
    vectors++;
    if (adc_start_o !== 1'b1 || adc_ch_o !== 3'd0 || err_o !== 1'b0 || class_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_restart strobe=%b ch=%0d err=%b valid=%b exp 1 0 0 0",
               adc_start_o, adc_ch_o, err_o, class_valid_o);
    end
    wait_valid();
    vectors++;
    if (edges !== 17 || feat_o !== 24'h654321 || class_o !== 2'd1) begin
      miscompares++;
      $display("FAIL b2b_result edges=%0d feat=%h cls=%0d exp 17 654321 1", edges, feat_o, class_o);
    end
  endtask

  task automatic test_hold_stall();
    int s0;
    s0 = strobe_cnt;
    class_i = 2'd3;
    for (int i = 0; i < 10; i++) begin
      start_i = i[0];
      @(posedge clk); #1;
      vectors++;
      if (class_o !== 2'd1 || class_valid_o !== 1'b1 || feat_o !== 24'h654321) begin
        miscompares++;
        $display("FAIL hold_stable cyc=%0d cls=%0d valid=%b feat=%h exp 1 1 654321",
                 i, class_o, class_valid_o, feat_o);
      end
    end
    start_i = 1'b0;
    vectors++;
    if (strobe_cnt !== s0) begin
      miscompares++;
      $display("FAIL hold_no_strobe got=%0d exp=%0d", strobe_cnt, s0);
    end
    release_hold();
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release busy=%b exp 0", busy_o);
    end
  endtask

  task automatic test_settle_class();
    accept();
    while (!class_valid_o && edges < 200) begin
      class_i = 2'(edges * 3 + 2);
      @(posedge clk); #1;
      edges++;
    end
    vectors++;
    if (edges !== 17 || class_o !== 2'd2) begin
      miscompares++;
      $display("FAIL settle_class edges=%0d cls=%0d exp 17 2", edges, class_o);
    end
    release_hold();
  endtask

  task automatic test_async_reset();
    skip_ch = 2;
    accept();
    repeat (5) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (adc_ch_o !== 3'd2 || busy_o !== 1'b1 || adc_start_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ch2_wait ch=%0d busy=%b strobe=%b exp 2 1 0", adc_ch_o, busy_o, adc_start_o);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy_o, adc_start_o, adc_ch_o, feat_o, class_o, class_valid_o, err_o} !== 33'd0) begin
      miscompares++;
      $display("FAIL async_reset got=%h exp=0",
               {busy_o, adc_start_o, adc_ch_o, feat_o, class_o, class_valid_o, err_o});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    skip_ch = -1;
    strobe_cnt = 0;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (strobe_cnt !== 0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle strobes=%0d busy=%b exp 0 0", strobe_cnt, busy_o);
    end
    accept();
    vectors++;
    if (adc_start_o !== 1'b1 || adc_ch_o !== 3'd0) begin
      miscompares++;
      $display("FAIL post_reset_start strobe=%b ch=%0d exp 1 0", adc_start_o, adc_ch_o);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_back_to_back();
    test_hold_stall();
    test_settle_class();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
